// File: rtl/dispatch_queue.sv
// dispatch_queue: DEPTH-entry in-order FIFO between decoder and issue units.
// The head reads rename state, allocates an ALU/LS tag, renames rd and issues.
// Ports: decoder side in_* / in_ready; regfile side rs*_name, reg_tag*, reg_data*;
// free-tag tables *_free_*; CDB cdb_*; rename en_wrt/wrt_*; issue *_en,
// operand_*, tag_*, name_w, op, addr, imm; occupancy count.
// Option: define CDB_BYPASS_EN to forward same-cycle CDB data into operands.
module dispatch_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_ROOT_W = 3,
    parameter int NAME_W     = 5,
    parameter int OP_W       = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_class,
    input  logic [OP_W-1:0]           in_op,
    input  logic [NAME_W-1:0]         in_rd,
    input  logic [NAME_W-1:0]         in_rs1,
    input  logic [NAME_W-1:0]         in_rs2,
    input  logic [DATA_W-1:0]         in_addr,
    input  logic [DATA_W-1:0]         in_imm,
    output logic [NAME_W-1:0]         rs1_name,
    output logic [NAME_W-1:0]         rs2_name,
    input  logic [TAG_ROOT_W:0]       reg_tag1,
    input  logic [TAG_ROOT_W:0]       reg_tag2,
    input  logic [DATA_W-1:0]         reg_data1,
    input  logic [DATA_W-1:0]         reg_data2,
    input  logic                      alu_free_valid,
    input  logic                      ls_free_valid,
    input  logic [TAG_ROOT_W-1:0]     alu_free_tag,
    input  logic [TAG_ROOT_W-1:0]     ls_free_tag,
    input  logic                      cdb_valid,
    input  logic [TAG_ROOT_W:0]       cdb_tag,
    input  logic [DATA_W-1:0]         cdb_data,
    output logic                      en_wrt,
    output logic [TAG_ROOT_W:0]       wrt_tag,
    output logic [NAME_W-1:0]         wrt_name,
    output logic                      alu_en,
    output logic                      br_en,
    output logic                      ls_en,
    output logic [DATA_W-1:0]         operand_o,
    output logic [DATA_W-1:0]         operand_t,
    output logic [TAG_ROOT_W:0]       tag_o,
    output logic [TAG_ROOT_W:0]       tag_t,
    output logic [TAG_ROOT_W:0]       tag_w,
    output logic [NAME_W-1:0]         name_w,
    output logic [OP_W-1:0]           op,
    output logic [DATA_W-1:0]         addr,
    output logic [DATA_W-1:0]         imm,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = TAG_ROOT_W + 1;
    localparam logic [TW-1:0] FREE = '1;

    localparam logic [3:0] C_LUI   = 4'd0;
    localparam logic [3:0] C_AUIPC = 4'd1;
    localparam logic [3:0] C_JAL   = 4'd2;
    localparam logic [3:0] C_JALR  = 4'd3;
    localparam logic [3:0] C_B     = 4'd4;
    localparam logic [3:0] C_LD    = 4'd5;
    localparam logic [3:0] C_ST    = 4'd6;
    localparam logic [3:0] C_RI    = 4'd7;
    localparam logic [3:0] C_RR    = 4'd8;

    typedef struct packed {
        logic [3:0]        cls;
        logic [OP_W-1:0]   op;
        logic [NAME_W-1:0] rd;
        logic [NAME_W-1:0] rs1;
        logic [NAME_W-1:0] rs2;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] imm;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    entry_t          hd;
    entry_t          in_entry;
    logic            head_valid, avail, fire, push;
    logic            is_alu, is_ls, is_br;
    logic [TW-1:0]   new_tag;
    logic [DATA_W-1:0] src1_data, src2_data;
    logic [TW-1:0]   src1_tag, src2_tag;

    assign hd         = mem_q[head_q];
    assign rs1_name   = hd.rs1;
    assign rs2_name   = hd.rs2;
    assign count      = count_q;
    assign head_valid = (count_q != '0);
    // No pass-through: a full queue refuses input even if the head pops.
    assign in_ready   = (count_q != CW'(DEPTH));
    assign push       = in_valid & in_ready & ~flush;

    assign in_entry.cls  = in_class;
    assign in_entry.op   = in_op;
    assign in_entry.rd   = in_rd;
    assign in_entry.rs1  = in_rs1;
    assign in_entry.rs2  = in_rs2;
    assign in_entry.addr = in_addr;
    assign in_entry.imm  = in_imm;

    always_comb begin
        is_alu = 1'b0;
        is_ls  = 1'b0;
        is_br  = 1'b0;
        unique case (hd.cls)
            C_LUI, C_AUIPC, C_JAL, C_JALR, C_RI, C_RR: is_alu = 1'b1;
            C_LD, C_ST: is_ls = 1'b1;
            C_B:        is_br = 1'b1;
            default: ;
        endcase
    end

    // Branches and invalid classes never wait for a tag.
    assign avail   = is_alu ? alu_free_valid : (is_ls ? ls_free_valid : 1'b1);
    assign fire    = head_valid & ~flush & ~rst & avail;
    assign new_tag = is_ls ? {1'b1, ls_free_tag} : {1'b0, alu_free_tag};

    always_comb begin
        src1_data = reg_data1;
        src1_tag  = reg_tag1;
        src2_data = reg_data2;
        src2_tag  = reg_tag2;
`ifdef CDB_BYPASS_EN
        if (reg_tag1 != FREE && cdb_valid && cdb_tag == reg_tag1) begin
            src1_data = cdb_data;
            src1_tag  = FREE;
        end
        if (reg_tag2 != FREE && cdb_valid && cdb_tag == reg_tag2) begin
            src2_data = cdb_data;
            src2_tag  = FREE;
        end
`endif
    end

`ifndef CDB_BYPASS_EN
    logic unused_cdb;
    assign unused_cdb = ^{cdb_valid, cdb_tag, cdb_data};
`endif

    always_comb begin
        alu_en    = 1'b0;
        br_en     = 1'b0;
        ls_en     = 1'b0;
        en_wrt    = 1'b0;
        wrt_tag   = FREE;
        wrt_name  = '0;
        operand_o = '0;
        operand_t = '0;
        tag_o     = FREE;
        tag_t     = FREE;
        tag_w     = FREE;
        name_w    = '0;
        op        = '0;
        addr      = '0;
        imm       = '0;
        if (fire && (is_alu || is_ls || is_br)) begin
            alu_en    = is_alu;
            br_en     = is_br;
            ls_en     = is_ls;
            op        = hd.op;
            addr      = hd.addr;
            imm       = hd.imm;
            name_w    = hd.rd;
            tag_w     = new_tag;
            operand_o = src1_data;
            tag_o     = src1_tag;
            operand_t = src2_data;
            tag_t     = src2_tag;
            unique case (hd.cls)
                C_LUI, C_AUIPC, C_JALR, C_RI: begin
                    operand_t = hd.imm;
                    tag_t     = FREE;
                end
                C_JAL: begin
                    operand_o = hd.addr;
                    tag_o     = FREE;
                    operand_t = hd.imm;
                    tag_t     = FREE;
                end
                C_B:  tag_w = FREE;
                C_LD: begin
                    operand_t = '0;
                    tag_t     = FREE;
                end
                C_ST: name_w = '0;
                C_RR: imm = '0;
                default: ;
            endcase
            // x0 destinations still consume a tag but are never renamed.
            if (hd.rd != '0 && hd.cls != C_B && hd.cls != C_ST) begin
                en_wrt   = 1'b1;
                wrt_tag  = new_tag;
                wrt_name = hd.rd;
            end
        end
    end

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q + AW'(fire);
        tail_d = tail_q + AW'(push);
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = in_entry;
        end
        if (push && !fire) begin
            count_d = count_q + 1'b1;
        end else if (!push && fire) begin
            count_d = count_q - 1'b1;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: random + directed stimulus against a queue-based model.
// A negedge monitor predicts issue/rename outputs from the model queue head.
module tb_dispatch_queue;
    localparam int DEPTH = 4;
    localparam logic [3:0] FREE = 4'hF;

    logic        clk, rst, flush, in_valid, in_ready;
    logic [3:0]  in_class;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_addr, in_imm;
    logic [4:0]  rs1_name, rs2_name;
    logic [3:0]  reg_tag1, reg_tag2;
    logic [31:0] reg_data1, reg_data2;
    logic        alu_free_valid, ls_free_valid;
    logic [2:0]  alu_free_tag, ls_free_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        en_wrt;
    logic [3:0]  wrt_tag;
    logic [4:0]  wrt_name;
    logic        alu_en, br_en, ls_en;
    logic [31:0] operand_o, operand_t;
    logic [3:0]  tag_o, tag_t, tag_w;
    logic [4:0]  name_w;
    logic [5:0]  op;
    logic [31:0] addr, imm;
    logic [2:0]  count;

    logic [3:0]  tag_tbl [32];
    logic [31:0] dat_tbl [32];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  cls;
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] addr, imm;
    } ins_t;
    ins_t mq[$];

    dispatch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_addr(in_addr), .in_imm(in_imm),
        .rs1_name(rs1_name), .rs2_name(rs2_name),
        .reg_tag1(reg_tag1), .reg_tag2(reg_tag2),
        .reg_data1(reg_data1), .reg_data2(reg_data2),
        .alu_free_valid(alu_free_valid), .ls_free_valid(ls_free_valid),
        .alu_free_tag(alu_free_tag), .ls_free_tag(ls_free_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .en_wrt(en_wrt), .wrt_tag(wrt_tag), .wrt_name(wrt_name),
        .alu_en(alu_en), .br_en(br_en), .ls_en(ls_en),
        .operand_o(operand_o), .operand_t(operand_t),
        .tag_o(tag_o), .tag_t(tag_t), .tag_w(tag_w),
        .name_w(name_w), .op(op), .addr(addr), .imm(imm),
        .count(count)
    );

    // Regfile model: answers the names the DUT presents.
    assign reg_tag1  = tag_tbl[rs1_name];
    assign reg_tag2  = tag_tbl[rs2_name];
    assign reg_data1 = dat_tbl[rs1_name];
    assign reg_data2 = dat_tbl[rs2_name];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register operand as the issue unit should see it.
    task automatic src(input logic [4:0] n, output logic [31:0] d,
                       output logic [3:0] t);
        t = tag_tbl[n];
        d = dat_tbl[n];
`ifdef CDB_BYPASS_EN
        if (t != FREE && cdb_valid && cdb_tag == t) begin
            d = cdb_data;
            t = FREE;
        end
`endif
    endtask

    always @(negedge clk) begin
        ins_t h;
        logic hv, fire, ia, il, ib, rdy;
        logic e_alu, e_br, e_ls, e_wrt;
        logic [3:0] e_wtag, e_otag, e_ttag, e_tagw, ftag, t1, t2;
        logic [4:0] e_wname, e_namew;
        logic [31:0] e_o, e_t, e_addr, e_imm, d1, d2;
        logic [5:0] e_op;
        e_alu = 0; e_br = 0; e_ls = 0; e_wrt = 0;
        e_wtag = FREE; e_otag = FREE; e_ttag = FREE; e_tagw = FREE;
        e_wname = 0; e_namew = 0;
        e_o = 0; e_t = 0; e_addr = 0; e_imm = 0; e_op = 0;
        hv = (mq.size() != 0);
        h = '{default: '0};
        if (hv) h = mq[0];
        ia = hv && (h.cls inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8});
        il = hv && (h.cls inside {4'd5, 4'd6});
        ib = hv && (h.cls == 4'd4);
        fire = hv && !flush && !rst &&
               (ia ? alu_free_valid : (il ? ls_free_valid : 1'b1));
        if (fire && (ia || il || ib)) begin
            ftag = il ? {1'b1, ls_free_tag} : {1'b0, alu_free_tag};
            src(h.rs1, d1, t1);
            src(h.rs2, d2, t2);
            e_op = h.op; e_addr = h.addr; e_imm = h.imm;
            e_namew = h.rd; e_tagw = ftag;
            case (h.cls)
                4'd2: begin e_alu = 1; e_o = h.addr; e_t = h.imm; end
                4'd4: begin
                    e_br = 1; e_o = d1; e_otag = t1;
                    e_t = d2; e_ttag = t2; e_tagw = FREE;
                end
                4'd5: begin e_ls = 1; e_o = d1; e_otag = t1; end
                4'd6: begin
                    e_ls = 1; e_o = d1; e_otag = t1;
                    e_t = d2; e_ttag = t2; e_namew = 0;
                end
                4'd8: begin
                    e_alu = 1; e_o = d1; e_otag = t1;
                    e_t = d2; e_ttag = t2; e_imm = 0;
                end
                default: begin e_alu = 1; e_o = d1; e_otag = t1; e_t = h.imm; end
            endcase
            if (h.cls != 4'd4 && h.cls != 4'd6 && h.rd != 0) begin
                e_wrt = 1; e_wtag = ftag; e_wname = h.rd;
            end
        end
        if (!rst) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            if (hv) begin
                chk("rs1_name", 64'(rs1_name), 64'(h.rs1));
                chk("rs2_name", 64'(rs2_name), 64'(h.rs2));
            end
        end
        chk("alu_en", 64'(alu_en), 64'(e_alu));
        chk("br_en", 64'(br_en), 64'(e_br));
        chk("ls_en", 64'(ls_en), 64'(e_ls));
        chk("en_wrt", 64'(en_wrt), 64'(e_wrt));
        chk("wrt_tag", 64'(wrt_tag), 64'(e_wtag));
        chk("wrt_name", 64'(wrt_name), 64'(e_wname));
        chk("operand_o", 64'(operand_o), 64'(e_o));
        chk("operand_t", 64'(operand_t), 64'(e_t));
        chk("tag_o", 64'(tag_o), 64'(e_otag));
        chk("tag_t", 64'(tag_t), 64'(e_ttag));
        chk("tag_w", 64'(tag_w), 64'(e_tagw));
        chk("name_w", 64'(name_w), 64'(e_namew));
        chk("op", 64'(op), 64'(e_op));
        chk("addr", 64'(addr), 64'(e_addr));
        chk("imm", 64'(imm), 64'(e_imm));
        rdy = (mq.size() < DEPTH);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (fire) void'(mq.pop_front());
            if (in_valid && rdy)
                mq.push_back('{in_class, in_op, in_rd, in_rs1, in_rs2,
                               in_addr, in_imm});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [3:0] c, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2);
        in_valid = 1; in_class = c; in_rd = rd; in_rs1 = r1; in_rs2 = r2;
        in_op = 6'($urandom); in_addr = $urandom; in_imm = $urandom;
        step();
        in_valid = 0;
    endtask

    task automatic rand_tables();
        for (int i = 0; i < 32; i++) begin
            tag_tbl[i] = ($urandom_range(0, 2) == 0) ? FREE
                                                     : 4'($urandom_range(0, 14));
            dat_tbl[i] = $urandom;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tag_tbl[i] = FREE;
            dat_tbl[i] = 32'h100 + i;
        end
        rst = 1; flush = 0; in_valid = 0; in_class = 0; in_op = 0;
        in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_addr = 0; in_imm = 0;
        alu_free_valid = 1; ls_free_valid = 1;
        alu_free_tag = 3'd2; ls_free_tag = 3'd0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        step(); step();
        rst = 0;
        @(negedge clk);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_tag_w", 64'(tag_w), 64'(FREE));
        step();

        // RR x3 = x1 + x2, both sources free, ALU tag 2.
        enq(4'd8, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        chk("tp_rr_alu_en", 64'(alu_en), 64'd1);
        chk("tp_rr_en_wrt", 64'(en_wrt), 64'd1);
        chk("tp_rr_wrt_tag", 64'(wrt_tag), 64'h2);
        chk("tp_rr_tag_o", 64'(tag_o), 64'hF);
        chk("tp_rr_tag_t", 64'(tag_t), 64'hF);
        step();

        // Fill with no ALU tag available, then drain.
        alu_free_valid = 0;
        for (int i = 0; i < 5; i++) enq(4'd7, 5'(i + 1), 5'(i), 5'd0);
        @(negedge clk);
        chk("tp_full_count", 64'(count), 64'd4);
        chk("tp_full_ready", 64'(in_ready), 64'd0);
        step();
        alu_free_valid = 1;
        for (int i = 0; i < 4; i++) begin
            alu_free_tag = 3'(i);
            step();
        end
        step();

        // ST with LS tag 5.
        ls_free_tag = 3'd5;
        enq(4'd6, 5'd9, 5'd4, 5'd5);
        @(negedge clk);
        chk("tp_st_ls_en", 64'(ls_en), 64'd1);
        chk("tp_st_tag_w", 64'(tag_w), 64'hD);
        chk("tp_st_en_wrt", 64'(en_wrt), 64'd0);
        chk("tp_st_name_w", 64'(name_w), 64'd0);
        step();

        // Branch issues with no ALU/LS tag available.
        alu_free_valid = 0; ls_free_valid = 0;
        enq(4'd4, 5'd0, 5'd6, 5'd7);
        @(negedge clk);
        chk("tp_b_br_en", 64'(br_en), 64'd1);
        step();
        alu_free_valid = 1; ls_free_valid = 1;

        // Load to x0: tag used, no rename.
        enq(4'd5, 5'd0, 5'd8, 5'd0);
        @(negedge clk);
        chk("tp_ld_ls_en", 64'(ls_en), 64'd1);
        chk("tp_ld_en_wrt", 64'(en_wrt), 64'd0);
        step();

        // Flush with three queued.
        alu_free_valid = 0;
        for (int i = 0; i < 3; i++) enq(4'd8, 5'd2, 5'd1, 5'd1);
        flush = 1;
        @(negedge clk);
        chk("tp_flush_alu_en", 64'(alu_en), 64'd0);
        step();
        flush = 0;
        alu_free_valid = 1;
        @(negedge clk);
        chk("tp_flush_count", 64'(count), 64'd0);
        step();

        // CDB broadcast matching rs1 tag in the fire cycle.
        tag_tbl[1] = 4'b0011;
        enq(4'd8, 5'd4, 5'd1, 5'd2);
        cdb_valid = 1; cdb_tag = 4'b0011; cdb_data = 32'h55;
        @(negedge clk);
`ifdef CDB_BYPASS_EN
        chk("tp_cdb_operand_o", 64'(operand_o), 64'h55);
        chk("tp_cdb_tag_o", 64'(tag_o), 64'hF);
`else
        chk("tp_cdb_operand_o", 64'(operand_o), 64'h101);
        chk("tp_cdb_tag_o", 64'(tag_o), 64'b0011);
`endif
        step();
        cdb_valid = 0;

        // Random phase.
        rand_tables();
        for (int i = 0; i < 3000; i++) begin
            if (i % 256 == 0) rand_tables();
            in_valid = ($urandom_range(0, 3) != 0);
            in_class = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15))
                                                    : 4'($urandom_range(0, 8));
            in_op = 6'($urandom);
            in_rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            in_rs1 = 5'($urandom);
            in_rs2 = 5'($urandom);
            in_addr = $urandom;
            in_imm = $urandom;
            alu_free_valid = ($urandom_range(0, 9) < 7);
            ls_free_valid = ($urandom_range(0, 9) < 6);
            alu_free_tag = 3'($urandom);
            ls_free_tag = 3'($urandom);
            flush = ($urandom_range(0, 31) == 0);
            rst = (i == 1500);
            cdb_valid = $urandom_range(0, 1);
            cdb_tag = ($urandom_range(0, 1) == 0) ? tag_tbl[5'($urandom)]
                                                  : 4'($urandom);
            cdb_data = $urandom;
            step();
        end
        rst = 0; flush = 0; in_valid = 0;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
